// File: rtl/dco_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dco_pkg : shared types, reset word and helpers for dco_word_ramp. Rev 1.0
// ---------------------------------------------------------------------------
package dco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    TRACK = 2'd2
  } state_e;

  localparam int unsigned WORD_W_DEF = 8;

  // Half-scale word; matches the row_col_cod half-on reset pattern.
  function automatic logic [31:0] rst_word(input int unsigned w);
    rst_word = 32'd1 << (w - 1);
  endfunction

  localparam logic [WORD_W_DEF-1:0] RST_WORD = WORD_W_DEF'(rst_word(WORD_W_DEF));

  function automatic logic [31:0] abs_diff(input logic signed [31:0] d);
    abs_diff = d[31] ? -d : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_dither1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_dither1 : first-order sigma-delta; carry is the overflow of acc+frac. Rev 1.0
// ---------------------------------------------------------------------------
module sd_dither1 #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              tick,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic [FRAC_W:0]   sum_w;

  // Carry is combinational so the caller registers it together with the word.
  assign sum_w = {1'b0, acc_q} + {1'b0, frac};
  assign carry = sum_w[FRAC_W];

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d = sum_w[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dco_word_ramp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dco_word_ramp : slew-limited tuning-word ramp with LSB sigma-delta dither. Rev 1.0
// ---------------------------------------------------------------------------
module dco_word_ramp
  import dco_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int FRAC_W = 4,
  parameter int STEP   = 4,
  parameter int DIV_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W+FRAC_W-1:0] tgt_word,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic [DIV_W-1:0]         upd_div,
  output logic [WORD_W-1:0]        word,
  output logic                     en,
  output logic                     busy,
  output logic                     settled
);

  localparam logic [WORD_W-1:0] RST_VAL = WORD_W'(rst_word(WORD_W));

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   tgt_int_q, tgt_int_d;
  logic [FRAC_W-1:0]   tgt_frac_q, tgt_frac_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                settled_q, settled_d;
  logic                ready_q, ready_d;

  logic                tick_w;
  logic                accept_w;
  logic                sd_tick_w;
  logic                carry_w;
  logic signed [WORD_W:0] diff_w;
  logic signed [31:0]  diff_ext_w;

  // A count above a freshly lowered upd_div wraps silently (no tick).
  assign tick_w = (cnt_q == upd_div);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (cnt_q >= upd_div) begin
      cnt_d = '0;
    end
  end

  assign accept_w   = tgt_valid & ready_q;
  assign sd_tick_w  = tick_w & (state_q == TRACK) & ~accept_w;
  assign diff_w     = $signed({1'b0, tgt_int_q}) - $signed({1'b0, word_q});
  assign diff_ext_w = {{(31-WORD_W){diff_w[WORD_W]}}, diff_w};

  sd_dither1 #(
    .FRAC_W (FRAC_W)
  ) u_sd (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_w),
    .tick  (sd_tick_w),
    .frac  (tgt_frac_q),
    .carry (carry_w)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    en_d       = 1'b0;
    tgt_int_d  = tgt_int_q;
    tgt_frac_d = tgt_frac_q;
    if (accept_w) begin
      tgt_int_d  = tgt_word[WORD_W+FRAC_W-1:FRAC_W];
      tgt_frac_d = tgt_word[FRAC_W-1:0];
      state_d    = RAMP;
    end else begin
      case (state_q)
        RAMP: begin
          if (tick_w) begin
            en_d = 1'b1;
            if (abs_diff(diff_ext_w) <= 32'(STEP)) begin
              word_d  = tgt_int_q;
              state_d = TRACK;
            end else if (diff_w[WORD_W]) begin
              word_d = word_q - WORD_W'(STEP);
            end else begin
              word_d = word_q + WORD_W'(STEP);
            end
          end
        end
        TRACK: begin
          if (tick_w) begin
            en_d = 1'b1;
            // Full-scale integer target saturates instead of wrapping.
            if (&tgt_int_q) begin
              word_d = tgt_int_q;
            end else begin
              word_d = tgt_int_q + WORD_W'(carry_w);
            end
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d    = (state_d == RAMP);
    settled_d = (state_d == TRACK);
    ready_d   = (state_d == IDLE) | (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tgt_int_q  <= '0;
      tgt_frac_q <= '0;
      word_q     <= RST_VAL;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      settled_q  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_int_q  <= tgt_int_d;
      tgt_frac_q <= tgt_frac_d;
      word_q     <= word_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      settled_q  <= settled_d;
      ready_q    <= ready_d;
    end
  end

  assign word      = word_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign settled   = settled_q;
  assign tgt_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_dco_word_ramp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dco_word_ramp : directed self-checking bench for dco_word_ramp. Rev 1.0
// ---------------------------------------------------------------------------
module tb_dco_word_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] tgt_word;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [3:0]  upd_div;
  logic [7:0]  word;
  logic        en;
  logic        busy;
  logic        settled;

  int checks = 0;
  int errors = 0;

  dco_word_ramp #(
    .WORD_W (8),
    .FRAC_W (4),
    .STEP   (4),
    .DIV_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_word  (tgt_word),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .upd_div   (upd_div),
    .word      (word),
    .en        (en),
    .busy      (busy),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (en !== 1'b1 && n < max);
    chk("en_timeout", {31'd0, en}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int idx;
    int sum;
    logic [7:0] prev;
    logic [7:0] ramp_exp [6];
    logic [7:0] dith_exp [4];
    logic [7:0] got [8];
    ramp_exp = '{8'h8E, 8'h92, 8'h96, 8'h9A, 8'h9E, 8'hA0};
    dith_exp = '{8'h40, 8'h41, 8'h40, 8'h41};

    // Reset state
    rst = 1'b1; tgt_valid = 1'b0; tgt_word = '0; upd_div = 4'd3;
    step(); step();
    rst = 1'b0;
    chk("rst_word", 32'(word), 32'h80);
    chk("rst_en", 32'(en), 0);
    chk("rst_ready", 32'(tgt_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_settled", 32'(settled), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (en !== 1'b0) bad++;
    end
    chk("idle_no_en", 32'(bad), 0);

    // Target equal to current word: rewrite unchanged on first tick
    tgt_word = 12'h800; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    chk("eq_busy", 32'(busy), 1);
    chk("eq_ready", 32'(tgt_ready), 0);
    wait_en(10, n);
    chk("eq_word", 32'(word), 32'h80);
    chk("eq_settled", 32'(settled), 1);

    // Ramp 0x80 -> 0x8C in steps of 4, ticks 4 cycles apart
    tgt_word = 12'h8C0; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    chk("r1_busy", 32'(busy), 1);
    wait_en(10, n);
    chk("r1_w84", 32'(word), 32'h84);
    chk("r1_busy84", 32'(busy), 1);
    wait_en(10, n);
    chk("r1_gap", 32'(n), 4);
    chk("r1_w88", 32'(word), 32'h88);
    wait_en(10, n);
    chk("r1_gap2", 32'(n), 4);
    chk("r1_w8c", 32'(word), 32'h8C);
    chk("r1_busy_fall", 32'(busy), 0);
    chk("r1_settled", 32'(settled), 1);
    chk("r1_ready", 32'(tgt_ready), 1);
    step();
    chk("r1_en_single", 32'(en), 0);

    // Single step 0x8C -> 0x8A
    tgt_word = 12'h8A0; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    wait_en(10, n);
    chk("r2_w8a", 32'(word), 32'h8A);
    chk("r2_settled", 32'(settled), 1);
    chk("r2_busy", 32'(busy), 0);

    // Long ramp to 0xA0 with the next target held valid throughout
    tgt_word = 12'hA00; tgt_valid = 1'b1;
    step();
    tgt_word = 12'h408;
    bad = 0; idx = 0;
    for (int i = 0; i < 200 && settled !== 1'b1; i++) begin
      step();
      if (busy === 1'b1 && tgt_ready !== 1'b0) bad++;
      if (en === 1'b1 && idx < 8) begin
        got[idx] = word;
        idx++;
      end
    end
    chk("hold_ready_low", 32'(bad), 0);
    chk("hold_steps", 32'(idx), 6);
    for (int i = 0; i < 6; i++) chk("hold_word", 32'(got[i]), 32'(ramp_exp[i]));
    step();
    tgt_valid = 1'b0;
    chk("hold_accept_busy", 32'(busy), 1);
    chk("hold_accept_ready", 32'(tgt_ready), 0);

    // Ramp down to 0x40, then dither 0x40.8
    for (int i = 0; i < 200 && settled !== 1'b1; i++) step();
    chk("d_settle_word", 32'(word), 32'h40);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wait_en(10, n);
      if (i < 4) chk("dither_word", 32'(word), 32'(dith_exp[i]));
      sum += int'(word);
    end
    chk("dither_mean_sum", 32'(sum), 32'd1032);

    // Full-scale target with upd_div=0: saturates at 0xFF, en continuous
    upd_div = 4'd0;
    tgt_word = 12'hFFF; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    bad = 0; prev = word;
    for (int i = 0; i < 100 && settled !== 1'b1; i++) begin
      step();
      if (word < prev) bad++;
      prev = word;
    end
    chk("ff_monotone", 32'(bad), 0);
    chk("ff_settle", 32'(word), 32'hFF);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (word !== 8'hFF || en !== 1'b1) bad++;
    end
    chk("ff_saturate_en", 32'(bad), 0);

    // Acceptance coincides with a TRACK tick: acceptance wins
    tgt_word = 12'hF00; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    chk("coinc_en", 32'(en), 0);
    chk("coinc_busy", 32'(busy), 1);
    chk("coinc_word", 32'(word), 32'hFF);
    step();
    chk("coinc_step", 32'(word), 32'hFB);

    // Reset mid-ramp; tick counter restarts
    upd_div = 4'd3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tgt_word = 12'hA00; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    wait_en(10, n);
    chk("mr_lat1", 32'(n), 3);
    chk("mr_w84", 32'(word), 32'h84);
    wait_en(10, n);
    chk("mr_w88", 32'(word), 32'h88);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_rst_word", 32'(word), 32'h80);
    chk("mr_rst_en", 32'(en), 0);
    chk("mr_rst_busy", 32'(busy), 0);
    chk("mr_rst_settled", 32'(settled), 0);
    chk("mr_rst_ready", 32'(tgt_ready), 1);
    tgt_word = 12'hA00; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    wait_en(10, n);
    chk("mr_lat2", 32'(n), 3);
    chk("mr_w84b", 32'(word), 32'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dco_word_ramp.md
Name: dco_word_ramp

Overview:
- Upstream stage of row_col_cod in the WSN DCO model.
- Accepts target tuning words (integer.fraction) from the ADPLL loop over a valid/ready handshake.
- Slews the integer word toward the target in bounded steps at a programmable update rate, then dithers the LSB with a first-order sigma-delta to realise the fractional part.
- Drives row_col_cod's word and en inputs directly.

Parameters:
- WORD_W, 8: integer word width; equals row_col_cod WORD_W.
- FRAC_W, 4: fractional bits of the target word.
- STEP, 4: maximum integer change per update tick; must satisfy 1 <= STEP < 2^WORD_W.
- DIV_W, 4: width of the update-period control.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- tgt_word  in  WORD_W+FRAC_W  target; [WORD_W+FRAC_W-1:FRAC_W] is the integer part, [FRAC_W-1:0] the fraction.
- tgt_valid  in  1  target valid.
- tgt_ready  out  1  block can accept a target.
- upd_div  in  DIV_W  update period = upd_div+1 clk cycles.
- word  out  WORD_W  tuning word to row_col_cod.word.
- en  out  1  one-cycle update strobe to row_col_cod.en.
- busy  out  1  ramp in progress.
- settled  out  1  integer target reached; dithering.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - word = 1<<(WORD_W-1), i.e. 0x80 for WORD_W=8. This matches the row_col_cod half-on reset.
  - en=0, busy=0, settled=0, tgt_ready=1.
  - tick counter=0, accumulator=0, state=IDLE.
- Tick counter:
  - Free-running from 0 to upd_div, then wraps to 0.
  - tick=1 in the cycle the counter equals upd_div.
  - upd_div is sampled live. If upd_div changes so the count is above the new value, the counter wraps to 0 on the next cycle without generating a tick.
- Handshake:
  - A target is accepted when tgt_valid & tgt_ready at a rising edge.
  - On acceptance, tgt_int and tgt_frac are latched, the accumulator is cleared, and the next state is RAMP.
  - tgt_ready = (state==IDLE) | (state==TRACK). tgt_ready is low throughout RAMP.
  - A target held valid during RAMP is accepted in the first TRACK cycle.
- State IDLE:
  - word holds its reset value; no en.
  - Transitions to RAMP on acceptance.
- State RAMP (busy=1), on each tick:
  - diff = tgt_int - word, signed, WORD_W+1 bits.
  - If |diff| <= STEP: word <= tgt_int, and state goes to TRACK.
  - Otherwise: word <= word ± STEP, with the sign of diff.
  - en=1 in the cycle after the tick edge, i.e. coincident with the new word value. row_col_cod captures at the following edge.
  - word never overshoots tgt_int and never wraps.
- State TRACK (settled=1), on each tick:
  - {carry, acc} <= acc + tgt_frac, using FRAC_W+1-bit arithmetic.
  - word <= tgt_int + carry.
  - Saturation: if tgt_int is all-ones, the carry is ignored and word = tgt_int.
  - en=1 coincident with the updated word, on every tick even if the value is unchanged.
  - tgt_frac = 0 gives a constant word.
- Priorities and boundary cases:
  - Acceptance in the same cycle as a TRACK tick: acceptance wins. No dither update, no en; next state is RAMP from the current word.
  - A target equal to the current word: RAMP lasts until the first tick, then word is rewritten unchanged with en=1, then TRACK.
  - rst asserted mid-ramp or mid-dither: all registers return to reset values at that edge; no en is issued.
- en is never high for two consecutive cycles unless upd_div=0. With upd_div=0, a tick occurs every cycle and en may be high continuously.

Decomposition:
- Shared package dco_pkg holds:
  - state encoding IDLE/RAMP/TRACK;
  - constant RST_WORD = 1<<(WORD_W-1);
  - a function abs_diff for signed WORD_W+1 values.
- One natural sub-module, sd_dither1: first-order sigma-delta with FRAC_W-bit accumulator, inputs clr, tick, frac; output carry.
- Tick counter and FSM stay in the top module.

Test Plan:
- Reset with WORD_W=8, upd_div=3 -> word=0x80, en=0, tgt_ready=1, busy=0, settled=0. No en for 20 cycles with no target.
- Target 0x8C.0 accepted -> on ticks 4 cycles apart word = 0x84, 0x88, 0x8C, each with a single-cycle en. busy falls and settled rises with the 0x8C update.
- From 0x8C, target 0x8A.0 -> a single step to 0x8A (|diff|=2 <= STEP), then TRACK. tgt_valid held during a long ramp -> tgt_ready=0 until TRACK, then accepted in that cycle.
- Target 0x40.8 (FRAC_W=4), after settling -> TRACK words 0x40, 0x41, 0x40, 0x41..., en on every tick, long-run mean 0x40.8.
- Target 0xFF.F -> word settles at 0xFF and never wraps to 0x00 during dithering.
- rst pulsed for one cycle mid-ramp (word=0x88, heading to 0xA0) -> next cycle word=0x80, state IDLE, en=0, busy=0, tick counter restarts from 0.
